// File: rtl/hart_mc.sv
// Multi-cycle RV32I hart with a single shared req/ready memory port for fetch and data.
// Latency: 4 cycles per non-memory instruction, 5 per load/store, plus 1 per memory wait cycle.
// Backpressure: mem_req holds addr/we/width/wdata stable until mem_ready, then drops for at least one cycle.
//
// Ports:
//   clk, reset        core clock; synchronous active-high reset
//   mem_req/mem_we    request valid / 1 = store
//   mem_addr          byte address (PC on fetch, ALU result on data access)
//   mem_wdata         store data (rs2), 0 unless storing
//   mem_width         00 byte, 01 half, 10 word (always 10 on fetch)
//   mem_sext          sign-extend load data (0 on fetch)
//   mem_ready         transfer completes this cycle
//   mem_rdata         read data, valid with mem_req & mem_ready & ~mem_we
//   halted            sticky halt indicator
//   pc_o              current PC
//   instret           retired-instruction count
// Optional feature macro: HART_MC_INSTRET_EN (64-bit instret counter; tied to 0 when undefined).
module hart_mc #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_width,
  output logic        mem_sext,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        halted,
  output logic [31:0] pc_o,
  output logic [63:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  state_t      state, state_nxt;
  // Low for the first cycle out of reset so no request is driven while reset is held.
  logic        boot;
  logic [31:0] pc, insn, rs1_val, rs2_val, imm, alu_res, next_pc, load_data;
  logic [31:0] rf [32];  // entry 0 is never written, so it always reads 0
  logic        wait_expired;

  // ---------------- decode (from the latched instruction) ----------------
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        f7b5;
  logic        is_jal, is_jalr, is_branch, is_load, is_store, is_op, is_opimm;
  logic        legal, rd_we;
  logic [31:0] imm_dec;

  assign opcode    = insn[6:0];
  assign rd        = insn[11:7];
  assign f3        = insn[14:12];
  assign rs1       = insn[19:15];
  assign rs2       = insn[24:20];
  assign f7b5      = insn[30];
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_op     = (opcode == OPC_OP);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign rd_we     = !(is_branch || is_store);

  always_comb begin
    legal   = 1'b0;
    imm_dec = {{20{insn[31]}}, insn[31:20]};
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        legal   = 1'b1;
        imm_dec = {insn[31:12], 12'h000};
      end
      OPC_JAL: begin
        legal   = 1'b1;
        imm_dec = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      end
      OPC_BRANCH: begin
        legal   = (f3[2:1] != 2'b01);
        imm_dec = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      end
      OPC_STORE: begin
        legal   = (f3 < 3'b011);
        imm_dec = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      end
      OPC_LOAD:            legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      OPC_JALR:            legal = (f3 == 3'b000);
      OPC_OP, OPC_OPIMM:   legal = 1'b1;
      // SYSTEM (ECALL/EBREAK), FENCE and everything else stop the hart.
      default:             legal = 1'b0;
    endcase
  end

  // ---------------- execute ----------------
  logic [3:0]  aluctl;
  logic [31:0] opb, alu_out, next_pc_c;
  logic        taken;

  assign opb = is_op ? rs2_val : imm;

  always_comb begin
    aluctl = 4'b0000;  // address calculation and everything else: ADD
    if (is_op)         aluctl = {f7b5, f3};
    else if (is_opimm) aluctl = {f7b5 & (f3 == 3'b101), f3};
  end

  always_comb begin
    alu_out = '0;
    case (aluctl)
      4'b0000:          alu_out = rs1_val + opb;
      4'b1000:          alu_out = rs1_val - opb;
      4'b0001, 4'b1001: alu_out = rs1_val << opb[4:0];
      4'b0010, 4'b1010: alu_out = {31'b0, $signed(rs1_val) < $signed(opb)};
      4'b0011, 4'b1011: alu_out = {31'b0, rs1_val < opb};
      4'b0100, 4'b1100: alu_out = rs1_val ^ opb;
      4'b0101:          alu_out = rs1_val >> opb[4:0];
      4'b1101:          alu_out = 32'($signed(rs1_val) >>> opb[4:0]);
      4'b0110, 4'b1110: alu_out = rs1_val | opb;
      default:          alu_out = rs1_val & opb;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000:  taken = (rs1_val == rs2_val);
      3'b001:  taken = (rs1_val != rs2_val);
      3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  taken = (rs1_val <  rs2_val);
      3'b111:  taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc_c = pc + 32'd4;
    if (is_jal || (is_branch && taken)) next_pc_c = pc + imm;
    else if (is_jalr)                   next_pc_c = (rs1_val + imm) & 32'hFFFF_FFFE;
  end

  // ---------------- writeback data ----------------
  logic [31:0] wb_data;
  always_comb begin
    case (opcode)
      OPC_LUI:           wb_data = imm;
      OPC_AUIPC:         wb_data = pc + imm;
      OPC_JAL, OPC_JALR: wb_data = pc + 32'd4;
      OPC_LOAD:          wb_data = load_data;
      default:           wb_data = alu_res;
    endcase
  end

  // ---------------- memory wait timeout ----------------
  generate
    if (MEM_WAIT_MAX > 0) begin : g_timeout
      logic [31:0] wait_cnt;
      always_ff @(posedge clk) begin
        if (reset)                       wait_cnt <= '0;
        else if (mem_req && !mem_ready)  wait_cnt <= wait_cnt + 32'd1;
        else                             wait_cnt <= '0;
      end
      assign wait_expired = mem_req && !mem_ready && ((wait_cnt + 32'd1) == MEM_WAIT_MAX);
    end else begin : g_no_timeout
      assign wait_expired = 1'b0;
    end
  endgenerate

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Memory outputs decode from registered state only; mem_ready only steers the next state.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_width = 2'b10;
    mem_sext  = 1'b0;
    case (state)
      S_FETCH: begin
        if (boot) begin
          if (pc[1:0] != 2'b00) begin
            state_nxt = S_HALT;  // misaligned target: no request is issued
          end else begin
            mem_req  = 1'b1;
            mem_addr = pc;
            if (mem_ready)         state_nxt = S_DECODE;
            else if (wait_expired) state_nxt = S_HALT;
          end
        end
      end
      S_DECODE: state_nxt = legal ? S_EXEC : S_HALT;
      S_EXEC:   state_nxt = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = is_store;
        mem_addr  = alu_res;  // misaligned addresses pass through untouched
        mem_wdata = is_store ? rs2_val : 32'h0;
        mem_width = f3[1:0];
        mem_sext  = ~f3[2];
        if (mem_ready)         state_nxt = S_WB;
        else if (wait_expired) state_nxt = S_HALT;
      end
      S_WB:     state_nxt = S_FETCH;
      default:  state_nxt = S_HALT;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      boot      <= 1'b0;
      pc        <= RESET_PC;
      insn      <= '0;
      rs1_val   <= '0;
      rs2_val   <= '0;
      imm       <= '0;
      alu_res   <= '0;
      next_pc   <= '0;
      load_data <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      boot <= 1'b1;
      case (state)
        S_FETCH:  if (mem_req && mem_ready) insn <= mem_rdata;
        S_DECODE: begin
          rs1_val <= rf[rs1];
          rs2_val <= rf[rs2];
          imm     <= imm_dec;
        end
        S_EXEC: begin
          alu_res <= alu_out;
          next_pc <= next_pc_c;
        end
        S_MEM:    if (mem_ready && !is_store) load_data <= mem_rdata;
        S_WB: begin
          pc <= next_pc;
          if (rd_we && rd != 5'd0) rf[rd] <= wb_data;
        end
        default: ;
      endcase
    end
  end

  assign halted = (state == S_HALT);
  assign pc_o   = pc;

`ifdef HART_MC_INSTRET_EN
  logic [63:0] instret_q;
  always_ff @(posedge clk) begin
    if (reset)              instret_q <= '0;
    else if (state == S_WB) instret_q <= instret_q + 64'd1;  // wraps naturally
  end
  assign instret = instret_q;
`else
  assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_hart_mc.sv
`timescale 1ns/1ps
module tb_hart_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_req, mem_we, mem_sext, halted;
  logic [31:0] mem_addr, mem_wdata, pc_o;
  logic [1:0]  mem_width;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [63:0] instret;

  // Second hart for the timeout case; its memory never answers.
  logic        to_reset;
  logic        to_ready = 1'b0;
  logic [31:0] to_rdata = 32'h0;
  logic        to_req, to_we, to_sext, to_halted;
  logic [31:0] to_addr, to_wdata, to_pc;
  logic [1:0]  to_width;
  logic [63:0] to_instret;

  hart_mc #(.RESET_PC(32'h0000_0000), .MEM_WAIT_MAX(0)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_width(mem_width), .mem_sext(mem_sext), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .halted(halted), .pc_o(pc_o), .instret(instret)
  );

  hart_mc #(.RESET_PC(32'h0000_0000), .MEM_WAIT_MAX(2)) u_to (
    .clk(clk), .reset(to_reset),
    .mem_req(to_req), .mem_we(to_we), .mem_addr(to_addr), .mem_wdata(to_wdata),
    .mem_width(to_width), .mem_sext(to_sext), .mem_ready(to_ready), .mem_rdata(to_rdata),
    .halted(to_halted), .pc_o(to_pc), .instret(to_instret)
  );

`ifdef HART_MC_INSTRET_EN
  localparam logic [63:0] IR_TWO = 64'd2;
  localparam logic [63:0] IR_RUN = 64'd24;
`else
  localparam logic [63:0] IR_TWO = 64'd0;
  localparam logic [63:0] IR_RUN = 64'd0;
`endif

  // Directed program; word 18 (0x48) is 0 and stops the hart as an illegal opcode.
  localparam logic [31:0] PROG [19] = '{
    32'h00500093,  // 00 addi x1,x0,5
    32'hFF908113,  // 04 addi x2,x1,-7
    32'h00202223,  // 08 sw   x2,4(x0)
    32'h00400183,  // 0C lb   x3,4(x0)
    32'h00404203,  // 10 lbu  x4,4(x0)
    32'h00400093,  // 14 addi x1,x0,4
    32'hFFF08093,  // 18 addi x1,x1,-1
    32'h00130313,  // 1C addi x6,x6,1
    32'hFE009CE3,  // 20 bne  x1,x0,-8
    32'h008002EF,  // 24 jal  x5,+8
    32'h00100393,  // 28 addi x7,x0,1   (skipped)
    32'h12345437,  // 2C lui  x8,0x12345
    32'h00001497,  // 30 auipc x9,1
    32'h04100567,  // 34 jalr x10,0x41(x0)
    32'h00100393,  // 38 addi x7,x0,1   (skipped)
    32'h00100393,  // 3C addi x7,x0,1   (skipped)
    32'h409405B3,  // 40 sub  x11,x8,x9
    32'h40115613,  // 44 srai x12,x2,1
    32'h00000000   // 48 illegal
  };

  localparam logic [31:0] EXP_RF [13] = '{
    32'h0, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h000000FE, 32'h28, 32'h4, 32'h0,
    32'h12345000, 32'h1030, 32'h38, 32'h12343FD0, 32'hFFFFFFFF
  };

  int checks = 0;
  int errors = 0;

  // ---------------- memory responder ----------------
  logic [31:0] mem [64];
  int          wait_cycles = 0;
  int          wait_ctr = 0;
  int          st_cnt = 0;
  logic [31:0] st_addr = 0, st_data = 0;
  logic [1:0]  st_width = 0;
  int          stable_err = 0, b2b_err = 0;
  logic        prev_req = 0, prev_ready = 0;
  logic [66:0] prev_bus = 0;

  always @(negedge clk) begin
    logic [31:0] w, mask;
    logic [4:0]  sh;
    logic [5:0]  idx;
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] = (i < 19) ? PROG[i] : 32'h0;
      st_cnt = 0; wait_ctr = 0; mem_ready = 0; mem_rdata = 32'hDEADBEEF;
      prev_req = 0; prev_ready = 0;
    end else begin
      if (mem_req && prev_req && !prev_ready &&
          {mem_we, mem_width, mem_addr, mem_wdata} != prev_bus) stable_err++;
      if (mem_req && prev_ready) b2b_err++;
      prev_req = mem_req;
      prev_bus = {mem_we, mem_width, mem_addr, mem_wdata};
      idx = mem_addr[7:2];
      sh  = {mem_addr[1:0], 3'b000};
      mem_rdata = 32'hDEADBEEF;
      if (!mem_req) begin
        mem_ready = 0; wait_ctr = 0;
      end else if (wait_ctr < wait_cycles) begin
        mem_ready = 0; wait_ctr++;
      end else begin
        mem_ready = 1; wait_ctr = 0;
        if (mem_we) begin
          mask = (mem_width == 2'b00) ? 32'hFF : (mem_width == 2'b01) ? 32'hFFFF : 32'hFFFFFFFF;
          mem[idx] = (mem[idx] & ~(mask << sh)) | ((mem_wdata & mask) << sh);
          st_cnt++; st_addr = mem_addr; st_width = mem_width; st_data = mem_wdata;
        end else begin
          w = mem[idx] >> sh;
          case (mem_width)
            2'b00:   mem_rdata = mem_sext ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
            2'b01:   mem_rdata = mem_sext ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
            default: mem_rdata = mem[idx];
          endcase
        end
      end
      prev_ready = mem_req && mem_ready;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_to_halt(input string tag);
    int n = 0;
    while (!halted && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_halt_reached"}, {63'b0, halted}, 64'd1);
  endtask

  task automatic check_results(input string tag);
    for (int i = 1; i < 13; i++)
      check($sformatf("%s_x%0d", tag, i), {32'b0, dut.rf[i]}, {32'b0, EXP_RF[i]});
    check({tag, "_pc"}, {32'b0, pc_o}, 64'h48);
    check({tag, "_instret"}, instret, IR_RUN);
    check({tag, "_mem1"}, {32'b0, mem[1]}, 64'hFFFFFFFE);
    check({tag, "_st_cnt"}, st_cnt, 1);
    check({tag, "_st_addr"}, {32'b0, st_addr}, 64'h4);
    check({tag, "_st_width"}, {62'b0, st_width}, 64'd2);
    check({tag, "_st_data"}, {32'b0, st_data}, 64'hFFFFFFFE);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    to_reset = 1'b1;
    wait_cycles = 0;
    repeat (3) @(negedge clk);

    // Reset state held while reset is asserted
    check("rst_req",   {63'b0, mem_req}, 0);
    check("rst_we",    {63'b0, mem_we}, 0);
    check("rst_addr",  {32'b0, mem_addr}, 0);
    check("rst_wdata", {32'b0, mem_wdata}, 0);
    check("rst_width", {62'b0, mem_width}, 2);
    check("rst_sext",  {63'b0, mem_sext}, 0);
    check("rst_halt",  {63'b0, halted}, 0);
    check("rst_pc",    {32'b0, pc_o}, 0);
    check("rst_instret", instret, 0);

    // Run 1: zero-wait memory
    reset = 1'b0;
    @(negedge clk);
    check("first_req",   {63'b0, mem_req}, 1);
    check("first_addr",  {32'b0, mem_addr}, 0);
    check("first_width", {62'b0, mem_width}, 2);
    repeat (8) @(negedge clk);
    check("c8_req",     {63'b0, mem_req}, 1);
    check("c8_addr",    {32'b0, mem_addr}, 8);
    check("c8_pc",      {32'b0, pc_o}, 8);
    check("c8_x2",      {32'b0, dut.rf[2]}, 64'hFFFFFFFE);
    check("c8_instret", instret, IR_TWO);
    run_to_halt("zw");
    check_results("zw");
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req) n++;
    end
    check("sticky_halt", {63'b0, halted}, 1);
    check("sticky_noreq", n, 0);

    // Run 2: three wait cycles on every access
    reset = 1'b1;
    wait_cycles = 3;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("w_first_req", {63'b0, mem_req}, 1);
    n = 0;
    while (mem_req && mem_addr == 32'h0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("w_req_hold", n, 4);
    run_to_halt("ws");
    check_results("ws");
    check("stable_bus", stable_err, 0);
    check("no_b2b", b2b_err, 0);

    // Run 3: reset pulse while the LB sits in MEM
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (!(mem_req && mem_width == 2'b00) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("lb_reached", {63'b0, mem_req && mem_width == 2'b00}, 1);
    check("lb_x3_before", {32'b0, dut.rf[3]}, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rp_req", {63'b0, mem_req}, 0);
    check("rp_pc",  {32'b0, pc_o}, 0);
    check("rp_x3",  {32'b0, dut.rf[3]}, 0);
    check("rp_x1",  {32'b0, dut.rf[1]}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rp_refetch_req",   {63'b0, mem_req}, 1);
    check("rp_refetch_addr",  {32'b0, mem_addr}, 0);
    check("rp_refetch_width", {62'b0, mem_width}, 2);

    // Timeout: MEM_WAIT_MAX=2 against a memory that never answers
    to_reset = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (to_req) n++;
    end
    check("to_req_cycles", n, 2);
    check("to_halted", {63'b0, to_halted}, 1);
    check("to_req_now", {63'b0, to_req}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
